// File: rtl/pccard_host_ctrl.sv
// pccard_host_ctrl: host-side PC Card bus initiator for the Gayle PCMCIA path.
// Turns a single-request CPU handshake into a timed card cycle (setup, strobe,
// hold) on common memory, attribute memory or I/O space. Every output is
// registered and aligned with the state register, so the strobe window is
// exactly as long as the state that drives it.
// Optional feature macro: PCC_TIMEOUT_EN bounds how long cc_wait may stretch
// the strobe. When it is defined, an expired access returns 16'hFFFF with err=1.
module pccard_host_ctrl #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  // CPU-side request
  input  logic        req,
  input  logic [1:0]  req_space,
  input  logic        req_we,
  input  logic [25:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  // card bus
  output logic [25:0] cc_addr,
  output logic [15:0] cc_dout,
  input  logic [15:0] cc_din,
  output logic        cc_reg,
  output logic        cc_oe,
  output logic        cc_we,
  output logic        cc_iord,
  output logic        cc_iowr,
  output logic        cc_ce1,
  output logic        cc_ce2,
  input  logic        cc_wait,
  input  logic        cc_ireq,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK
  } state_t;

  localparam logic [1:0] SPACE_COMMON = 2'b00;
  localparam logic [1:0] SPACE_IO     = 2'b10;
  localparam logic [1:0] SPACE_RSVD   = 2'b11;

  // The counter is sized to hold the largest timing parameter unchanged.
  localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_SSH = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int unsigned MAX_CYC = (MAX_SSH > TIMEOUT_CYC) ? MAX_SSH : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         space_q;
  logic               we_q;
  logic [1:0]         be_q;
  logic [15:0]        rd_cap;
  logic               ireq_s1;
  logic               accept_bus;
  logic               accept_null;
  logic               timeout_hit;
  logic               is_io;
  logic               unused_addr0;

  // Bit 0 of the byte address is rebuilt from the byte enables.
  assign unused_addr0 = req_addr[0];

  assign accept_bus  = (state_q == IDLE) && req && (req_be != 2'b00) && (req_space != SPACE_RSVD);
  assign accept_null = (state_q == IDLE) && req && !accept_bus;
  assign is_io       = (space_q == SPACE_IO);

`ifdef PCC_TIMEOUT_EN
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             to_q;
`endif

  // Card read data placed on the CPU lanes; the unused byte reads as FFh.
  function automatic logic [15:0] lane_rd(input logic [1:0] be, input logic [15:0] din);
    case (be)
      2'b11:   lane_rd = din;
      2'b01:   lane_rd = {8'hFF, din[7:0]};
      default: lane_rd = {din[7:0], 8'hFF};
    endcase
  endfunction

  // CPU write data placed on the card lanes; an odd byte travels on [7:0].
  function automatic logic [15:0] lane_wr(input logic [1:0] be, input logic [15:0] wd);
    lane_wr = (be == 2'b10) ? {wd[15:8], wd[15:8]} : wd;
  endfunction

  // Next-state logic: one down-counter reloaded on every state entry.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
`ifdef PCC_TIMEOUT_EN
    wcnt_d      = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_bus) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end else if (accept_null) begin
          state_d = ACK;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
`ifdef PCC_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          // cc_wait is not looked at until the minimum strobe has elapsed.
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cc_wait) begin
`ifdef PCC_TIMEOUT_EN
          if (wcnt_q == CNT_W'(TIMEOUT_CYC)) begin
            timeout_hit = 1'b1;
            state_d     = HOLD;
            cnt_d       = CNT_W'(HOLD_CYC - 1);
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
`endif
        end else begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, latched request and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q <= IDLE;
      cnt_q   <= '0;
      space_q <= 2'b00;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      rd_cap  <= 16'h0000;
`ifdef PCC_TIMEOUT_EN
      wcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PCC_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      if (accept_bus) begin
        to_q <= 1'b0;
      end else if (timeout_hit) begin
        to_q <= 1'b1;
      end
`endif
      if (accept_bus) begin
        space_q <= req_space;
        we_q    <= req_we;
        be_q    <= req_be;
      end
      // Card data is taken in the last strobe cycle, as the strobe ends.
      if ((state_q == STROBE) && (state_d == HOLD) && !we_q) begin
        rd_cap <= timeout_hit ? 16'hFFFF : lane_rd(be_q, cc_din);
      end
    end
  end

  // Registered bus and handshake outputs, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 16'h0000;
      cc_addr <= '0;
      cc_dout <= '0;
      cc_reg  <= 1'b0;
      cc_oe   <= 1'b0;
      cc_we   <= 1'b0;
      cc_iord <= 1'b0;
      cc_iowr <= 1'b0;
      cc_ce1  <= 1'b0;
      cc_ce2  <= 1'b0;
    end else begin
      ack     <= (state_d == ACK);
      busy    <= (state_d != IDLE);
      cc_oe   <= (state_d == STROBE) && !is_io && !we_q;
      cc_we   <= (state_d == STROBE) && !is_io &&  we_q;
      cc_iord <= (state_d == STROBE) &&  is_io && !we_q;
      cc_iowr <= (state_d == STROBE) &&  is_io &&  we_q;
      if (accept_bus) begin
        cc_addr <= {req_addr[25:1], (req_be == 2'b10)};
        cc_dout <= req_we ? lane_wr(req_be, req_wdata) : 16'h0000;
        cc_ce1  <= 1'b1;
        cc_ce2  <= (req_be == 2'b11);
        cc_reg  <= (req_space != SPACE_COMMON);
      end else if ((state_d == ACK) || (state_d == IDLE)) begin
        cc_ce1 <= 1'b0;
        cc_ce2 <= 1'b0;
        cc_reg <= 1'b0;
      end
      // rdata changes only when an access completes; writes leave it alone.
      if (accept_null) begin
        rdata <= 16'hFFFF;
      end else if ((state_d == ACK) && (state_q == HOLD) && !we_q) begin
        rdata <= rd_cap;
      end
    end
  end

`ifdef PCC_TIMEOUT_EN
  // Error flag accompanies the ack of an access that timed out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (state_d == ACK) && (state_q == HOLD) && to_q;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous card interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ireq_s1 <= 1'b0;
      irq     <= 1'b0;
    end else begin
      ireq_s1 <= cc_ireq;
      irq     <= ireq_s1;
    end
  end

endmodule

// File: tb/tb_pccard_host_ctrl.sv
// Self-checking bench for pccard_host_ctrl: directed vector table, randomized
// accesses against a behavioural model, and hand-written multi-cycle sequences.
module tb_pccard_host_ctrl;

  localparam int SETUP  = 2;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int TMO    = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  req_space;
  logic        req_we;
  logic [25:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  logic [25:0] cc_addr;
  logic [15:0] cc_dout;
  logic [15:0] cc_din;
  logic        cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2;
  logic        cc_wait;
  logic        cc_ireq;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pccard_host_ctrl #(
    .SETUP_CYC  (SETUP),
    .STROBE_CYC (STROBE),
    .HOLD_CYC   (HOLD),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_space(req_space),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy),
    .cc_addr  (cc_addr),
    .cc_dout  (cc_dout),
    .cc_din   (cc_din),
    .cc_reg   (cc_reg),
    .cc_oe    (cc_oe),
    .cc_we    (cc_we),
    .cc_iord  (cc_iord),
    .cc_iowr  (cc_iowr),
    .cc_ce1   (cc_ce1),
    .cc_ce2   (cc_ce2),
    .cc_wait  (cc_wait),
    .cc_ireq  (cc_ireq),
    .irq      (irq)
  );

  // Expected outcome of one access. kind: 0 none, 1 oe, 2 we, 3 iord, 4 iowr.
  typedef struct {
    int          lat;
    int          slen;
    int          kind;
    logic        ce2;
    logic        creg;
    logic [25:0] addr;
    logic [7:0]  dlo;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  sp;
    logic        we;
    logic [25:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] din;
    int          extra;
    exp_t        e;
  } vec_t;

  // Observed outcome of the last access.
  int          r_lat, r_slen, r_setup, r_hold, r_kind;
  logic        r_multi, r_ce1, r_ce2, r_reg, r_acked, r_err;
  logic [25:0] r_addr;
  logic [15:0] r_dout, r_rdata;
  logic [15:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: what the card bus and CPU should see for one access.
  function automatic exp_t model(input logic [1:0] sp, input logic we, input logic [25:0] a,
                                 input logic [1:0] be, input logic [15:0] wd,
                                 input logic [15:0] din, input int extra,
                                 input logic [15:0] prev);
    exp_t e;
    bit   active;
    active  = (be != 2'b00) && (sp != 2'b11);
    e.lat   = active ? (1 + SETUP + STROBE + extra + HOLD) : 1;
    e.slen  = active ? (STROBE + extra) : 0;
    e.kind  = !active ? 0 : (sp == 2'b10) ? (we ? 4 : 3) : (we ? 2 : 1);
    e.ce2   = active && (be == 2'b11);
    e.creg  = active && (sp != 2'b00);
    e.addr  = {a[25:1], (be == 2'b10)};
    e.dlo   = (be == 2'b10) ? wd[15:8] : wd[7:0];
    if (!active)         e.rdata = 16'hFFFF;
    else if (we)         e.rdata = prev;
    else if (be == 2'b11) e.rdata = din;
    else if (be == 2'b01) e.rdata = {8'hFF, din[7:0]};
    else                 e.rdata = {din[7:0], 8'hFF};
    e.err = 1'b0;
    return e;
  endfunction

  // Drives one request and records what the bus did until ack or budget expiry.
  // cc_wait stays high until the strobe has run 'STROBE+extra' cycles, and
  // cc_din carries the real data only in that final strobe cycle.
  task automatic run_access(input logic [1:0] sp, input logic we, input logic [25:0] a,
                            input logic [1:0] be, input logic [15:0] wd,
                            input logic [15:0] din, input int extra, input int budget);
    int total;
    int sc;
    int n;
    int guard;
    total = STROBE + extra;
    sc    = 0;
    guard = 0;
    while (busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    req = 1'b1; req_space = sp; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
    cc_din = ~din; cc_wait = 1'b1;
    r_lat = 0; r_slen = 0; r_setup = 0; r_hold = 0; r_kind = 0;
    r_multi = 0; r_ce1 = 0; r_ce2 = 0; r_reg = 0; r_acked = 0; r_err = 0;
    r_addr = '0; r_dout = '0; r_rdata = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        // The request is latched; scramble the CPU side to show it is ignored.
        req       = 1'b0;
        req_addr  = 26'($urandom);
        req_wdata = 16'($urandom);
        req_be    = 2'($urandom);
        req_space = 2'($urandom);
        req_we    = 1'($urandom);
      end
      n = 0;
      if (cc_oe)   begin n++; r_kind = 1; end
      if (cc_we)   begin n++; r_kind = 2; end
      if (cc_iord) begin n++; r_kind = 3; end
      if (cc_iowr) begin n++; r_kind = 4; end
      if (n > 1) r_multi = 1'b1;
      if (n != 0) begin
        sc++;
        if (sc == 1) begin
          r_addr = cc_addr; r_dout = cc_dout;
          r_ce1 = cc_ce1; r_ce2 = cc_ce2; r_reg = cc_reg;
        end
      end else if (cc_ce1 || cc_ce2 || cc_reg) begin
        if (sc == 0) r_setup++;
        else         r_hold++;
      end
      r_slen  = sc;
      cc_wait = (sc < total);
      cc_din  = ((n != 0) && (sc == total)) ? din : ~din;
      if (ack) begin
        r_lat = cyc; r_rdata = rdata; r_err = err; r_acked = 1'b1;
        break;
      end
    end
    cc_wait = 1'b0;
  endtask

  task automatic verify(input string tag, input exp_t e, input logic we);
    bit active;
    active = (e.slen != 0);
    check({tag, " acked"}, 32'(r_acked), 32'd1);
    check({tag, " latency"}, 32'(r_lat), 32'(e.lat));
    check({tag, " strobe_len"}, 32'(r_slen), 32'(e.slen));
    check({tag, " strobe_kind"}, 32'(r_kind), 32'(e.kind));
    check({tag, " one_strobe"}, 32'(r_multi), 32'd0);
    check({tag, " setup_len"}, 32'(r_setup), active ? 32'(SETUP) : 32'd0);
    check({tag, " hold_len"}, 32'(r_hold), active ? 32'(HOLD) : 32'd0);
    check({tag, " ce1"}, 32'(r_ce1), 32'(active));
    check({tag, " ce2"}, 32'(r_ce2), 32'(e.ce2));
    check({tag, " reg"}, 32'(r_reg), 32'(e.creg));
    if (active) check({tag, " cc_addr"}, 32'(r_addr), 32'(e.addr));
    if (active && we) check({tag, " dout_lo"}, 32'(r_dout[7:0]), 32'(e.dlo));
    check({tag, " rdata"}, 32'(r_rdata), 32'(e.rdata));
    check({tag, " err"}, 32'(r_err), 32'(e.err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    int   a1, a2;
    logic [15:0] d1, d2;
    logic [1:0]  sp;
    logic        we;
    logic [25:0] a;
    logic [1:0]  be;
    logic [15:0] wd, din;
    int          extra;

    reset = 1'b1; req = 1'b0; req_space = '0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; cc_din = '0; cc_wait = 1'b0; cc_ireq = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset strobes", {cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2, cc_reg}, 32'd0);
    check("reset ack_busy_err_irq", {ack, busy, err, irq}, 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset cc_addr", 32'(cc_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_rdata = 16'h0000;

    // ---- directed vector table ----
    //          sp     we    addr         be     wdata     din      extra  lat slen kind ce2 reg  cc_addr     dlo    rdata     err
    vecs[0] = '{2'b01, 1'b0, 26'h000002, 2'b11, 16'h0000, 16'h0041, 0,  '{8,  4,  1, 1'b1, 1'b1, 26'h000002, 8'h00, 16'h0041, 1'b0}};
    vecs[1] = '{2'b00, 1'b1, 26'h001001, 2'b10, 16'hA500, 16'h0000, 0,  '{8,  4,  2, 1'b0, 1'b0, 26'h001001, 8'hA5, 16'h0041, 1'b0}};
    vecs[2] = '{2'b10, 1'b0, 26'h0003F0, 2'b11, 16'h0000, 16'h1234, 10, '{18, 14, 3, 1'b1, 1'b1, 26'h0003F0, 8'h00, 16'h1234, 1'b0}};
    vecs[3] = '{2'b00, 1'b0, 26'h000100, 2'b00, 16'h0000, 16'h5555, 0,  '{1,  0,  0, 1'b0, 1'b0, 26'h000100, 8'h00, 16'hFFFF, 1'b0}};
    vecs[4] = '{2'b11, 1'b1, 26'h000200, 2'b11, 16'h7777, 16'h0000, 0,  '{1,  0,  0, 1'b0, 1'b0, 26'h000200, 8'h77, 16'hFFFF, 1'b0}};
    vecs[5] = '{2'b10, 1'b1, 26'h000301, 2'b01, 16'h12C3, 16'h0000, 2,  '{10, 6,  4, 1'b0, 1'b1, 26'h000300, 8'hC3, 16'hFFFF, 1'b0}};
    vecs[6] = '{2'b00, 1'b0, 26'h3FFFFFE, 2'b01, 16'h0000, 16'hABCD, 0, '{8,  4,  1, 1'b0, 1'b0, 26'h3FFFFFE, 8'h00, 16'hFFCD, 1'b0}};
    vecs[7] = '{2'b01, 1'b0, 26'h000200, 2'b10, 16'h0000, 16'h5A77, 0,  '{8,  4,  1, 1'b0, 1'b1, 26'h000201, 8'h00, 16'h77FF, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].sp, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd,
                 vecs[i].din, vecs[i].extra, vecs[i].e.lat + 10);
      verify($sformatf("vec%0d", i), vecs[i].e, vecs[i].we);
    end
    m_rdata = 16'h77FF;

    // ---- randomized accesses against the model ----
    for (int i = 0; i < 40; i++) begin
      sp    = 2'($urandom);
      we    = 1'($urandom);
      a     = 26'($urandom);
      be    = 2'($urandom);
      wd    = 16'($urandom);
      din   = 16'($urandom);
      extra = int'($urandom_range(0, 5));
      e = model(sp, we, a, be, wd, din, extra, m_rdata);
      run_access(sp, we, a, be, wd, din, extra, e.lat + 10);
      verify($sformatf("rnd%0d", i), e, we);
      m_rdata = e.rdata;
    end

    // ---- cc_wait stuck high ----
`ifdef PCC_TIMEOUT_EN
    run_access(2'b10, 1'b0, 26'h000040, 2'b11, 16'h0000, 16'h4444, 1000, 400);
    e = model(2'b10, 1'b0, 26'h000040, 2'b11, 16'h0000, 16'h4444, TMO, m_rdata);
    e.rdata = 16'hFFFF;
    e.err   = 1'b1;
    verify("timeout", e, 1'b0);
    m_rdata = 16'hFFFF;
`else
    run_access(2'b10, 1'b0, 26'h000040, 2'b11, 16'h0000, 16'h4444, 1000, 300);
    check("stuck_wait no_ack", 32'(r_acked), 32'd0);
    check("stuck_wait busy", 32'(busy), 32'd1);
    check("stuck_wait iord", 32'(cc_iord), 32'd1);
    check("stuck_wait strobe_len", 32'(r_slen), 32'd298);
    cc_wait = 1'b0;
    cc_din  = 16'h4444;
    a1 = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (ack) begin
        a1 = cyc;
        d1 = rdata;
        break;
      end
    end
    check("stuck_wait release_lat", 32'(a1), 32'd2);
    check("stuck_wait rdata", 32'(d1), 32'h4444);
    m_rdata = 16'h4444;
`endif

    // ---- reset in the third strobe cycle ----
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b1; req_space = 2'b00; req_we = 1'b1; req_addr = 26'h2ABCDE;
    req_be = 2'b11; req_wdata = 16'hBEEF; cc_wait = 1'b0;
    a1 = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (cc_we) a1++;
      if (a1 == 3) break;
    end
    check("midrst reached_strobe3", 32'(a1), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("midrst bus_zero", {cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2, cc_reg}, 32'd0);
    check("midrst addr_dout_zero", {6'd0, cc_addr}, 32'd0);
    check("midrst ack_busy_zero", {ack, busy}, 32'd0);
    a2 = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack) a2++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      if (ack) a2++;
    end
    check("midrst no_ack", 32'(a2), 32'd0);
    m_rdata = 16'h0000;
    e = model(2'b01, 1'b0, 26'h000010, 2'b11, 16'h0000, 16'hC0DE, 1, m_rdata);
    run_access(2'b01, 1'b0, 26'h000010, 2'b11, 16'h0000, 16'hC0DE, 1, e.lat + 10);
    verify("after_rst", e, 1'b0);
    m_rdata = e.rdata;

    // ---- req held high: back-to-back accesses ----
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b1; req_space = 2'b01; req_we = 1'b0; req_addr = 26'h000020;
    req_be = 2'b11; cc_wait = 1'b0; cc_din = 16'h9C3E;
    a1 = 0; a2 = 0; d1 = '0; d2 = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (a1 == 0) begin
          a1 = cyc; d1 = rdata;
        end else begin
          a2 = cyc; d2 = rdata;
          req = 1'b0;
          break;
        end
      end
    end
    req = 1'b0;
    check("b2b first_ack", 32'(a1), 32'd8);
    check("b2b second_ack", 32'(a2), 32'd17);
    check("b2b rdata1", 32'(d1), 32'h9C3E);
    check("b2b rdata2", 32'(d2), 32'h9C3E);

    // ---- interrupt synchronizer ----
    @(posedge clk); #1;
    cc_ireq = 1'b1;
    @(posedge clk); #1;
    check("irq rise_after_1clk", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq rise_after_2clk", 32'(irq), 32'd1);
    cc_ireq = 1'b0;
    @(posedge clk); #1;
    check("irq fall_after_1clk", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("irq fall_after_2clk", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pccard_host_ctrl.md
Name: pccard_host_ctrl

Overview:
Host-side PC Card bus initiator for the Gayle PCMCIA path. It turns a single-request CPU-side handshake into a timed card bus cycle on the attribute, common-memory or I/O space:
- drives cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1 and cc_ce2 with programmable setup, strobe and hold
- honours card wait
- returns read data and the card interrupt to the chipset

It is the counterpart of the card-side NE2000 responder.

Parameters:
- SETUP_CYC, 2, cycles address/CE/REG are valid before the strobe (min 1)
- STROBE_CYC, 4, minimum cycles the strobe is asserted (min 1)
- HOLD_CYC, 1, cycles address/CE/data are held after the strobe falls (min 1)
- TIMEOUT_CYC, 255, maximum extra strobe cycles while cc_wait is high (used only with PCC_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  access request, level; sampled only in IDLE
- req_space  in  2  00 common memory, 01 attribute memory, 10 I/O, 11 reserved
- req_we  in  1  1 = write, 0 = read
- req_addr  in  26  card byte address; bit 0 is ignored, the block drives it
- req_be  in  2  byte enables: [1] odd byte = req_wdata[15:8], [0] even byte = req_wdata[7:0]
- req_wdata  in  16  write data
- ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid from the ack cycle until the next access completes
- err  out  1  with ack: access timed out (PCC_TIMEOUT_EN only, else tied 0)
- busy  out  1  high in every state except IDLE
- cc_addr  out  26  card address
- cc_dout  out  16  card write data
- cc_din  in  16  card read data
- cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2  out  1 each  active-high card strobes
- cc_wait  in  1  card wait, active high
- cc_ireq  in  1  card interrupt, asynchronous
- irq  out  1  cc_ireq after a 2-flop synchronizer

Behaviour:

Reset:
- All outputs are registered and go to 0 asynchronously, including the synchronizer flops.
- State becomes IDLE.
- A reset mid-access drops every strobe immediately and no ack is issued.

States: IDLE, SETUP, STROBE, HOLD, ACK.

IDLE:
- Accept when req=1. Latch space, we, addr, be and wdata.
- Byte lane mapping:
  - be=11: cc_addr[0]=0, ce1=ce2=1, 16-bit
  - be=01: cc_addr[0]=0, ce1 only, data on lane [7:0]
  - be=10: cc_addr[0]=1, ce1 only, cc_dout[7:0]=wdata[15:8]
- If be=00 or space=11, go directly to ACK with no bus activity; rdata=16'hFFFF.
- Otherwise go to SETUP.

SETUP (SETUP_CYC cycles):
- cc_addr, ce1/ce2 and cc_dout (writes) are valid.
- cc_reg=1 for attribute and I/O spaces, 0 for common memory.
- No strobe is asserted.

STROBE (at least STROBE_CYC cycles):
- Exactly one strobe is asserted:
  - oe: memory read
  - we: memory write
  - iord: I/O read
  - iowr: I/O write
- After the minimum count, stay in STROBE while cc_wait=1; cc_wait is ignored before the count expires.
- Reads latch cc_din in the last STROBE cycle:
  - 16-bit access: rdata=cc_din
  - even byte: rdata={8'hFF, cc_din[7:0]}
  - odd byte: rdata={cc_din[7:0], 8'hFF}

HOLD (HOLD_CYC cycles):
- Strobe is 0; address, CE, REG and dout are unchanged.

ACK:
- One cycle: ack=1, all CE and REG = 0; then return to IDLE.
- req may stay high; the next access is accepted in IDLE.

Latency:
- Request sampled at cycle N gives ack at N+1+SETUP+STROBE(+wait)+HOLD.
- With defaults and no wait, ack is at N+8.
- The bus is idle for at least 2 cycles between accesses (ACK, IDLE).

Other rules:
- A single down-counter is reloaded at each state entry; parameters are stored as-is, no width wrap.
- Inputs other than cc_din, cc_wait and cc_ireq are not sampled outside IDLE.

Optional Feature:
PCC_TIMEOUT_EN.
- Defined:
  - A counter runs while STROBE is extended by cc_wait.
  - If it reaches TIMEOUT_CYC, the strobe ends and the block enters HOLD.
  - The read result is forced to 16'hFFFF and err=1 with ack.
- Undefined:
  - cc_wait can extend STROBE indefinitely.
  - err is constant 0.

Test Plan:
1. Attribute read, addr 26'h000002, be=11, card returns 16'h0041, no wait -> cc_reg and cc_oe high for 4 cycles, ce1=ce2=1, ack 8 cycles after req, rdata=16'h0041, err=0.
2. Common-memory odd-byte write, addr 26'h001001, be=10, wdata=16'hA500 -> cc_addr[0]=1, ce1=1, ce2=0, cc_reg=0, cc_we for 4 cycles, cc_dout[7:0]=8'hA5.
3. I/O read with cc_wait held 10 cycles past the minimum -> cc_iord high for 14 cycles, ack at N+18, data sampled in the last strobe cycle.
4. Timeout (macro on, TIMEOUT_CYC=255), cc_wait stuck high -> strobe drops after 4+255 cycles, ack with err=1 and rdata=16'hFFFF; with the macro off, busy stays high.
5. Assert reset in cycle 3 of STROBE -> all cc_* go to 0 asynchronously, no ack; the next req completes normally.
6. Toggle cc_ireq, and issue req with be=00 -> irq follows after 2 clocks; the be=00 request acks at N+1 with no strobes asserted.
